// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer with saturating counters and true-LRU
//
// Purpose:
//   IF-stage branch target buffer. The lookup on predictPc is combinational.
//   Resolved branches from EX update the table on the clock edge. Replacement
//   within a set is true LRU, tracked as a permutation of per-way ages.
//   Branches that hit but resolve not-taken stay resident; only their
//   direction counter weakens.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   predictPc       fetch PC to look up
//   predictHit      a valid way in the indexed set matches the tag
//   predict         hit and direction counter in the taken half
//   predictTarget   target of the hit way, 0 on miss
//   update          resolved branch info valid this cycle
//   br              resolved direction (1 = taken)
//   updatePc        PC of the resolved branch
//   updateTarget    resolved target
//   flush           synchronous invalidate-all; takes priority over update
//   statsHits       count of applied updates that hit
//   statsEvicts     count of allocations that replaced a valid entry
//
// Configuration:
//   BTB_STATS_EN    when defined, builds the statsHits/statsEvicts counters;
//                   otherwise both outputs are tied to 0

module btb_assoc #(
    parameter int SET_LEN  = 4,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 2,
    parameter int PC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] predictPc,
    output logic        predictHit,
    output logic        predict,
    output logic [31:0] predictTarget,
    input  logic        update,
    input  logic        br,
    input  logic [31:0] updatePc,
    input  logic [31:0] updateTarget,
    input  logic        flush,
    output logic [31:0] statsHits,
    output logic [31:0] statsEvicts
);

    localparam int SETS  = 1 << SET_LEN;
    localparam int TAG_W = 32 - PC_ALIGN - SET_LEN;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK   = CNT_W'(1) << (CNT_W - 1);
    localparam logic [AGE_W-1:0] AGE_OLDEST = AGE_W'(WAYS - 1);

    // Table storage. Tags and targets are not cleared by reset or flush,
    // because the valid bits already hide stale contents.
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [31:0]      target_q [SETS][WAYS];
    logic [CNT_W-1:0] cnt_q    [SETS][WAYS];
    logic [AGE_W-1:0] age_q    [SETS][WAYS];

    // ------------------------------------------------------------------
    // Lookup (combinational; reads the pre-update state, no bypass)
    // ------------------------------------------------------------------
    logic [SET_LEN-1:0] p_idx;
    logic [TAG_W-1:0]   p_tag;
    logic               p_hit;
    logic               p_taken;
    logic [31:0]        p_target;

    assign p_idx = predictPc[PC_ALIGN +: SET_LEN];
    assign p_tag = predictPc[31 -: TAG_W];

    always_comb begin
        p_hit    = 1'b0;
        p_taken  = 1'b0;
        p_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!p_hit && valid_q[p_idx][w] && (tag_q[p_idx][w] == p_tag)) begin
                p_hit    = 1'b1;
                p_taken  = cnt_q[p_idx][w][CNT_W-1];
                p_target = target_q[p_idx][w];
            end
        end
    end

    assign predictHit    = p_hit;
    assign predict       = p_taken;
    assign predictTarget = p_target;

    // ------------------------------------------------------------------
    // Update-side match and victim selection
    // ------------------------------------------------------------------
    logic [SET_LEN-1:0] u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               u_hit;
    logic [AGE_W-1:0]   u_way;
    logic               inv_found;
    logic [AGE_W-1:0]   inv_way;
    logic [AGE_W-1:0]   lru_way;
    logic [AGE_W-1:0]   victim;

    assign u_idx = updatePc[PC_ALIGN +: SET_LEN];
    assign u_tag = updatePc[31 -: TAG_W];

    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!u_hit && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = AGE_W'(w);
            end
            if (!inv_found && !valid_q[u_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_q[u_idx][w] == AGE_OLDEST) begin
                lru_way = AGE_W'(w);
            end
        end
        victim = inv_found ? inv_way : lru_way;
    end

    logic             apply;
    logic             do_hit;
    logic             do_alloc;
    logic             victim_valid;
    logic [AGE_W-1:0] touch_way;

    assign apply        = update && !flush;
    assign do_hit       = apply && u_hit;
    assign do_alloc     = apply && !u_hit && br;
    assign victim_valid = valid_q[u_idx][victim];
    assign touch_way    = u_hit ? u_way : victim;

    // ------------------------------------------------------------------
    // Next-state for the touched set: LRU ages and the hit counter
    // ------------------------------------------------------------------
    logic [AGE_W-1:0] touch_age;
    logic [AGE_W-1:0] age_d [WAYS];
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_d;

    // Moving the touched way to age 0 and shifting only the younger ways
    // keeps the ages a permutation of 0..WAYS-1.
    always_comb begin
        touch_age = age_q[u_idx][touch_way];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touch_way) begin
                age_d[w] = '0;
            end else if (age_q[u_idx][w] < touch_age) begin
                age_d[w] = age_q[u_idx][w] + AGE_W'(1);
            end else begin
                age_d[w] = age_q[u_idx][w];
            end
        end
    end

    always_comb begin
        cnt_cur = cnt_q[u_idx][u_way];
        if (br) begin
            cnt_d = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
        end else begin
            cnt_d = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    cnt_q[s][w] <= '0;
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    cnt_q[s][w] <= '0;
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (do_hit || do_alloc) begin
            for (int w = 0; w < WAYS; w++) begin
                age_q[u_idx][w] <= age_d[w];
            end
            if (do_hit) begin
                cnt_q[u_idx][u_way] <= cnt_d;
                if (br) begin
                    target_q[u_idx][u_way] <= updateTarget;
                end
            end else begin
                valid_q[u_idx][victim]  <= 1'b1;
                tag_q[u_idx][victim]    <= u_tag;
                target_q[u_idx][victim] <= updateTarget;
                cnt_q[u_idx][victim]    <= CNT_WEAK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BTB_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] evicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            evicts_q <= '0;
        end else begin
            if (do_hit) begin
                hits_q <= hits_q + 32'd1;
            end
            if (do_alloc && victim_valid) begin
                evicts_q <= evicts_q + 32'd1;
            end
        end
    end

    assign statsHits   = hits_q;
    assign statsEvicts = evicts_q;
`else
    logic unused_victim_valid;
    assign unused_victim_valid = victim_valid;
    assign statsHits   = '0;
    assign statsEvicts = '0;
`endif

    // The alignment bits below PC_ALIGN never reach the index or the tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{predictPc, updatePc};

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - self-checking bench for btb_assoc
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] predictPc;
    logic        predictHit;
    logic        predict;
    logic [31:0] predictTarget;
    logic        update;
    logic        br;
    logic [31:0] updatePc;
    logic [31:0] updateTarget;
    logic        flush;
    logic [31:0] statsHits;
    logic [31:0] statsEvicts;

    always #5 clk = ~clk;

    btb_assoc dut (
        .clk          (clk),
        .rst          (rst),
        .predictPc    (predictPc),
        .predictHit   (predictHit),
        .predict      (predict),
        .predictTarget(predictTarget),
        .update       (update),
        .br           (br),
        .updatePc     (updatePc),
        .updateTarget (updateTarget),
        .flush        (flush),
        .statsHits    (statsHits),
        .statsEvicts  (statsEvicts)
    );

    typedef enum int {OP_UPD, OP_LOOK, OP_FLUSH_UPD, OP_RST, OP_STATS} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        br;
        logic        eh;
        logic        ep;
        logic [31:0] et;
        string       name;
    } vec_t;

    typedef struct {
        logic        eh;
        logic        ep;
        logic [31:0] et;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(op_e op, logic [31:0] pc, logic [31:0] tgt, logic b,
                                logic eh, logic ep, logic [31:0] et, string name);
        vec_t v;
        v.op = op; v.pc = pc; v.tgt = tgt; v.br = b;
        v.eh = eh; v.ep = ep; v.et = et; v.name = name;
        return v;
    endfunction

    function automatic logic [31:0] exp_stat(int n);
`ifdef BTB_STATS_EN
        return 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops one expected lookup result and compares it with the live outputs.
    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at sample point");
            return;
        end
        e = sb.pop_front();
        chk({e.name, " hit"},    32'(predictHit), 32'(e.eh));
        chk({e.name, " pred"},   32'(predict),    32'(e.ep));
        chk({e.name, " target"}, predictTarget,   e.et);
    endtask

    task automatic push_exp(logic eh, logic ep, logic [31:0] et, string name);
        exp_t e;
        e.eh = eh; e.ep = ep; e.et = et; e.name = name;
        sb.push_back(e);
    endtask

    // Every task starts and ends just after a rising edge.
    task automatic do_update(logic [31:0] pc, logic [31:0] tgt, logic b, logic fl);
        update = 1'b1; updatePc = pc; updateTarget = tgt; br = b; flush = fl;
        @(posedge clk); #1;
        update = 1'b0; flush = 1'b0;
    endtask

    task automatic do_lookup(logic [31:0] pc, logic eh, logic ep, logic [31:0] et, string name);
        predictPc = pc;
        push_exp(eh, ep, et, name);
        @(negedge clk);
        sb_check();
        @(posedge clk); #1;
    endtask

    task automatic run_vec(vec_t v);
        case (v.op)
            OP_UPD:       do_update(v.pc, v.tgt, v.br, 1'b0);
            OP_FLUSH_UPD: do_update(v.pc, v.tgt, v.br, 1'b1);
            OP_LOOK:      do_lookup(v.pc, v.eh, v.ep, v.et, v.name);
            OP_RST: begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            OP_STATS: begin
                @(negedge clk);
                chk({v.name, " statsHits"},   statsHits,   exp_stat(int'(v.pc)));
                chk({v.name, " statsEvicts"}, statsEvicts, exp_stat(int'(v.tgt)));
                @(posedge clk); #1;
            end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; update = 1'b0; br = 1'b0; flush = 1'b0;
        updatePc = '0; updateTarget = '0; predictPc = 32'h100;

        // Reset state, sampled while reset is held.
        @(posedge clk); #1;
        push_exp(1'b0, 1'b0, 32'h0, "reset");
        @(negedge clk);
        sb_check();
        chk("reset statsHits",   statsHits,   32'h0);
        chk("reset statsEvicts", statsEvicts, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Set index is pc[5:2]: 0x100/0x140/0x180/0x1C0/0x200/0x240 share set 0.
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 0, 0, 32'h0,   "s1 empty"));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h200, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 1, 1, 32'h200, "s2 alloc"));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h999, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 1, 0, 32'h200, "s2 cnt1"));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h999, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h999, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 1, 0, 32'h200, "s2 cnt0 resident"));
        vecs.push_back(mk(OP_STATS, 32'd3, 32'd0, 0, 0, 0, 0, "s2"));
        vecs.push_back(mk(OP_RST,   0, 0, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_STATS, 32'd0, 32'd0, 0, 0, 0, 0, "s3 after rst"));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h200, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_UPD,   32'h140, 32'h240, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_UPD,   32'h100, 32'h200, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_UPD,   32'h180, 32'h280, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h140, 0, 0, 0, 0, 32'h0,   "s3 lru evicted"));
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 1, 1, 32'h200, "s3 mru kept"));
        vecs.push_back(mk(OP_LOOK,  32'h180, 0, 0, 1, 1, 32'h280, "s3 new entry"));
        vecs.push_back(mk(OP_STATS, 32'd1, 32'd1, 0, 0, 0, 0, "s3"));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(OP_UPD, 32'h104, 32'h300, 1, 0, 0, 0, ""));
        end
        vecs.push_back(mk(OP_LOOK,  32'h104, 0, 0, 1, 1, 32'h300, "s4 sat"));
        vecs.push_back(mk(OP_UPD,   32'h104, 32'h777, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h104, 0, 0, 1, 1, 32'h300, "s4 cnt2"));
        vecs.push_back(mk(OP_UPD,   32'h104, 32'h777, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h104, 0, 0, 1, 0, 32'h300, "s4 cnt1"));
        vecs.push_back(mk(OP_STATS, 32'd7, 32'd1, 0, 0, 0, 0, "s4"));
        vecs.push_back(mk(OP_FLUSH_UPD, 32'h108, 32'h400, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h100, 0, 0, 0, 0, 32'h0,   "s5 flushed 0x100"));
        vecs.push_back(mk(OP_LOOK,  32'h108, 0, 0, 0, 0, 32'h0,   "s5 dropped 0x108"));
        vecs.push_back(mk(OP_LOOK,  32'h104, 0, 0, 0, 0, 32'h0,   "s5 flushed 0x104"));
        vecs.push_back(mk(OP_STATS, 32'd7, 32'd1, 0, 0, 0, 0, "s5 kept"));
        vecs.push_back(mk(OP_UPD,   32'h200, 32'h500, 0, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h200, 0, 0, 0, 0, 32'h0,   "s6 no alloc nt"));
        vecs.push_back(mk(OP_UPD,   32'h200, 32'h500, 1, 0, 0, 0, ""));
        vecs.push_back(mk(OP_LOOK,  32'h200, 0, 0, 1, 1, 32'h500, "s6 alloc"));

        foreach (vecs[i]) run_vec(vecs[i]);

        // No bypass: the lookup in the update cycle sees the old state.
        predictPc = 32'h1C0;
        update = 1'b1; br = 1'b1; updatePc = 32'h1C0; updateTarget = 32'h600;
        push_exp(1'b0, 1'b0, 32'h0, "nobypass same cycle");
        @(negedge clk);
        sb_check();
        @(posedge clk); #1;
        update = 1'b0;
        push_exp(1'b1, 1'b1, 32'h600, "nobypass next cycle");
        @(negedge clk);
        sb_check();
        chk("nobypass statsEvicts", statsEvicts, exp_stat(1));
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle with an update pending across the edge.
        predictPc = 32'h200;
        update = 1'b1; br = 1'b1; updatePc = 32'h240; updateTarget = 32'h700;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst hit",    32'(predictHit), 32'h0);
        chk("async rst pred",   32'(predict),    32'h0);
        chk("async rst target", predictTarget,   32'h0);
        chk("async rst statsHits", statsHits,    32'h0);
        @(posedge clk); #1;
        rst = 1'b0; update = 1'b0;
        do_lookup(32'h240, 1'b0, 1'b0, 32'h0, "rst drops update");
        do_lookup(32'h200, 1'b0, 1'b0, 32'h0, "rst cleared 0x200");

        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
